// File: rtl/call_stack_pkg.sv
// Shared types and width helpers for the return-address stack.
package call_stack_pkg;
    localparam int INSTR_ADDR_SIZE_DEF = 5;

    typedef logic [INSTR_ADDR_SIZE_DEF-1:0] instr_addr_t;

    // Depth counter must represent 0..n inclusive.
    function automatic int depth_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Index width for n entries (at least one bit).
    function automatic int index_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/call_stack.sv
// Return-address LIFO beside the program counter: pushes instr_addr+1 on call, pops on ret.
// Single-cycle update, no handshake; full/empty and sticky overflow/underflow flags report misuse.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int INSTR_ADDR_SIZE = 5,
    parameter int STACK_DEPTH     = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                call,
    input  logic                                ret,
    input  logic [INSTR_ADDR_SIZE-1:0]          instr_addr,
    input  logic                                clr_err,
    output logic [INSTR_ADDR_SIZE-1:0]          ret_addr,
    output logic [depth_w(STACK_DEPTH)-1:0]     depth,
    output logic                                empty,
    output logic                                full,
    output logic                                overflow,
    output logic                                underflow
);
    localparam int DW = depth_w(STACK_DEPTH);
    localparam int AW = index_w(STACK_DEPTH);

    logic [INSTR_ADDR_SIZE-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]              depth_q;
    logic [DW-1:0]              top_full;
    logic [AW-1:0]              top_idx;
    logic [AW-1:0]              wr_idx;
    logic                       push;
    logic                       pop;
    logic                       ovf_evt;
    logic                       udf_evt;

    assign empty    = (depth_q == '0);
    assign full     = (depth_q == DW'(STACK_DEPTH));
    assign depth    = depth_q;

    // Call takes priority over ret, matching the counter's jmp-over-ret order.
    assign push     = call && !full;
    assign pop      = ret && !call && !empty;
    assign ovf_evt  = call && full;
    assign udf_evt  = ret && !call && empty;

    assign top_full = depth_q - DW'(1);
    assign top_idx  = top_full[AW-1:0];
    assign wr_idx   = depth_q[AW-1:0];
    assign ret_addr = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                depth_q <= depth_q + DW'(1);
            end else if (pop) begin
                depth_q <= depth_q - DW'(1);
            end
            // A new error in the same cycle as clr_err keeps the flag set.
            overflow  <= ovf_evt || (overflow  && !clr_err);
            underflow <= udf_evt || (underflow && !clr_err);
        end
    end

    // Storage is intentionally not reset; depth alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_idx] <= instr_addr + INSTR_ADDR_SIZE'(1);
        end
    end
endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: directed vector table, hand-written overflow sequence, randomized run vs queue model.
module tb_call_stack;
    logic       clk = 1'b0;
    logic       rst, call, ret, clr_err;
    logic [4:0] instr_addr;
    logic [4:0] ret_addr;
    logic [3:0] depth;
    logic       empty, full, overflow, underflow;

    int n_cmp = 0;
    int n_bad = 0;

    call_stack #(.INSTR_ADDR_SIZE(5), .STACK_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .call(call), .ret(ret), .instr_addr(instr_addr),
        .clr_err(clr_err), .ret_addr(ret_addr), .depth(depth), .empty(empty),
        .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, call, ret, clr;
        logic [4:0] addr;
        int         d, r;
        logic       o, u;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic rs, input logic c, input logic rt, input logic cl,
                                input int a, input int d, input int r, input logic o, input logic u);
        vec_t v;
        v.rst = rs; v.call = c; v.ret = rt; v.clr = cl; v.addr = 5'(a);
        v.d = d; v.r = r; v.o = o; v.u = u;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int d, input int r, input logic o, input logic u);
        check({tag, " depth"}, int'(depth), d);
        check({tag, " ret_addr"}, int'(ret_addr), r);
        check({tag, " empty"}, int'(empty), int'(d == 0));
        check({tag, " full"}, int'(full), int'(d == 8));
        check({tag, " overflow"}, int'(overflow), int'(o));
        check({tag, " underflow"}, int'(underflow), int'(u));
    endtask

    task automatic step(input logic rs, input logic c, input logic rt, input logic cl, input logic [4:0] a);
        rst = rs; call = c; ret = rt; clr_err = cl; instr_addr = a;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue of return addresses plus two sticky bits.
    int   q[$];
    logic m_ovf, m_udf;

    task automatic model_step(input logic rs, input logic c, input logic rt, input logic cl, input logic [4:0] a);
        logic eo, eu;
        if (rs) begin
            q.delete(); m_ovf = 0; m_udf = 0;
        end else begin
            eo = c && (q.size() == 8);
            eu = rt && !c && (q.size() == 0);
            if (c && q.size() < 8) q.push_back((int'(a) + 1) % 32);
            else if (rt && !c && q.size() > 0) void'(q.pop_back());
            m_ovf = eo || (m_ovf && !cl);
            m_udf = eu || (m_udf && !cl);
        end
    endtask

    initial begin
        rst = 1; call = 0; ret = 0; clr_err = 0; instr_addr = '0;

        vecs[0]  = mk(1,0,0,0, 0, 0,0, 0,0);
        vecs[1]  = mk(1,0,0,0, 0, 0,0, 0,0);
        vecs[2]  = mk(0,0,0,0, 0, 0,0, 0,0);
        vecs[3]  = mk(0,1,0,0, 3, 1,4, 0,0);
        vecs[4]  = mk(0,1,0,0,10, 2,11,0,0);
        vecs[5]  = mk(0,1,0,0,20, 3,21,0,0);
        vecs[6]  = mk(0,0,1,0, 0, 2,11,0,0);
        vecs[7]  = mk(0,0,1,0, 0, 1,4, 0,0);
        vecs[8]  = mk(0,0,1,0, 0, 0,0, 0,0);
        vecs[9]  = mk(0,1,0,0,31, 1,0, 0,0);
        vecs[10] = mk(0,0,1,0, 0, 0,0, 0,0);
        vecs[11] = mk(0,0,1,0, 0, 0,0, 0,1);
        vecs[12] = mk(0,0,0,1, 0, 0,0, 0,0);
        vecs[13] = mk(0,0,1,1, 0, 0,0, 0,1);
        vecs[14] = mk(0,0,0,1, 0, 0,0, 0,0);
        vecs[15] = mk(0,1,0,0, 2, 1,3, 0,0);
        vecs[16] = mk(0,1,0,0, 5, 2,6, 0,0);
        vecs[17] = mk(0,1,1,0, 9, 3,10,0,0);
        vecs[18] = mk(1,1,0,0, 7, 0,0, 0,0);
        vecs[19] = mk(0,0,0,0, 0, 0,0, 0,0);

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst, vecs[i].call, vecs[i].ret, vecs[i].clr, vecs[i].addr);
            check_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].r, vecs[i].o, vecs[i].u);
        end

        // Fill to full, then a 9th call must be dropped and flag overflow.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 5'(i));
            check($sformatf("fill%0d ret_addr", i), int'(ret_addr), i + 1);
        end
        step(0, 1, 0, 0, 5'd15);
        check_all("ovf", 8, 8, 1, 0);
        step(0, 1, 0, 1, 5'd15);
        check("ovf with clr overflow", int'(overflow), 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d ret_addr", i), int'(ret_addr), 8 - i);
            step(0, 0, 1, 0, 5'd0);
        end
        check_all("drained", 0, 0, 1, 0);
        step(0, 0, 0, 1, 5'd0);
        check("ovf cleared", int'(overflow), 0);

        // Randomized run against the queue model.
        step(1, 0, 0, 0, 5'd0);
        model_step(1, 0, 0, 0, 5'd0);
        for (int i = 0; i < 2000; i++) begin
            logic rs, c, rt, cl;
            logic [4:0] a;
            rs = ($urandom_range(63) == 0);
            c  = ($urandom_range(99) < 45);
            rt = ($urandom_range(99) < 45);
            cl = ($urandom_range(15) == 0);
            a  = 5'($urandom_range(31));
            step(rs, c, rt, cl, a);
            model_step(rs, c, rt, cl, a);
            check_all($sformatf("rnd%0d", i), q.size(), (q.size() > 0) ? q[$] : 0, m_ovf, m_udf);
            if (n_bad > 20) break;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
